// File: rtl/seven_segment_scan_controller.sv
// ---------------------------------------------------------------------------
// seven_segment_scan_controller
//
// Time-multiplexes eight hex digits onto one shared 7-segment bus. A
// prescaler produces one refresh tick every DIV clocks; each tick advances
// the digit index. Display data is captured into shadow registers once per
// frame, when the index wraps from 7 back to 0, so a frame never shows a
// mix of old and new input values. After every digit change the segments
// are held dark for BLANK clocks. This hides the "ghost" image that would
// otherwise appear while the external anode driver switches over.
//
// Parameters
//   DIV   : clocks per digit slot (>= 2)
//   BLANK : dark clocks after each digit change (0 <= BLANK < DIV)
//
// Ports
//   clk         : clock, rising edge
//   rst         : asynchronous active-high reset
//   en          : scan enable; low freezes prescaler, index and blanking
//   digits      : eight hex nibbles, digit k is digits[4k+3:4k]
//   digit_en    : per-digit enable, a 0 bit keeps that digit dark
//   dp          : per-digit decimal point request, active high
//   sel         : current digit index for the anode selector
//   seg_n       : segments {g,f,e,d,c,b,a}, active low
//   dp_n        : decimal point, active low
//   frame_start : one-clock pulse in the cycle after the 7->0 wrap
// ---------------------------------------------------------------------------
module seven_segment_scan_controller #(
    parameter int DIV   = 100000,
    parameter int BLANK = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] digits,
    input  logic [7:0]  digit_en,
    input  logic [7:0]  dp,
    output logic [2:0]  sel,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic        frame_start
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = (BLANK > 0) ? $clog2(BLANK + 1) : 1;
    localparam logic [CW-1:0] PRESC_LAST = CW'(DIV - 1);
    localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK);
    localparam logic [6:0]    SEG_OFF    = 7'h7F;

    logic [CW-1:0] prescCnt_q, prescCnt_d;
    logic [BW-1:0] blankCnt_q, blankCnt_d;
    logic [2:0]    sel_q, sel_d;
    logic [31:0]   shadowDigits_q, shadowDigits_d;
    logic [7:0]    shadowEn_q, shadowEn_d;
    logic [7:0]    shadowDp_q, shadowDp_d;
    logic [6:0]    segN_q, segN_d;
    logic          dpN_q, dpN_d;
    logic          frameStart_q, frameStart_d;
    logic          tick;
    logic          wrap;
    logic [3:0]    nibble;

    // Active-low segment pattern for one hex nibble (lowercase b and d so
    // they cannot be confused with 8 and 0).
    function automatic logic [6:0] hexDecode(input logic [3:0] value);
        logic [6:0] pattern;
        case (value)
            4'h0:    pattern = 7'b1000000;
            4'h1:    pattern = 7'b1111001;
            4'h2:    pattern = 7'b0100100;
            4'h3:    pattern = 7'b0110000;
            4'h4:    pattern = 7'b0011001;
            4'h5:    pattern = 7'b0010010;
            4'h6:    pattern = 7'b0000010;
            4'h7:    pattern = 7'b1111000;
            4'h8:    pattern = 7'b0000000;
            4'h9:    pattern = 7'b0010000;
            4'hA:    pattern = 7'b0001000;
            4'hB:    pattern = 7'b0000011;
            4'hC:    pattern = 7'b1000110;
            4'hD:    pattern = 7'b0100001;
            4'hE:    pattern = 7'b0000110;
            default: pattern = 7'b0001110;
        endcase
        return pattern;
    endfunction

    // Next-state logic. The segment outputs are computed from the *next*
    // index, blank count and shadow contents. This lets the registered
    // outputs change on the same edge as sel and never lag it by a cycle.
    // With en low every next value equals the current one, so the whole
    // scan, outputs included, simply freezes.
    always_comb begin
        tick = en && (prescCnt_q == PRESC_LAST);
        wrap = tick && (sel_q == 3'd7);

        prescCnt_d = prescCnt_q;
        if (en) begin
            prescCnt_d = tick ? '0 : prescCnt_q + CW'(1);
        end

        sel_d = tick ? sel_q + 3'd1 : sel_q;

        blankCnt_d = blankCnt_q;
        if (tick) begin
            blankCnt_d = BLANK_LOAD;
        end else if (en && (blankCnt_q != '0)) begin
            blankCnt_d = blankCnt_q - BW'(1);
        end

        shadowDigits_d = wrap ? digits   : shadowDigits_q;
        shadowEn_d     = wrap ? digit_en : shadowEn_q;
        shadowDp_d     = wrap ? dp       : shadowDp_q;
        frameStart_d   = wrap;

        nibble = shadowDigits_d[{sel_d, 2'b00} +: 4];

        segN_d = SEG_OFF;
        dpN_d  = 1'b1;
        if ((blankCnt_d == '0) && shadowEn_d[sel_d]) begin
            segN_d = hexDecode(nibble);
            dpN_d  = ~shadowDp_d[sel_d];
        end
    end

    // State and output registers. Reset darkens the display at once and
    // clears the shadow enables. This keeps the first frame after reset
    // dark until real data is captured at the first wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescCnt_q     <= '0;
            blankCnt_q     <= '0;
            sel_q          <= 3'd0;
            shadowDigits_q <= 32'd0;
            shadowEn_q     <= 8'd0;
            shadowDp_q     <= 8'd0;
            segN_q         <= SEG_OFF;
            dpN_q          <= 1'b1;
            frameStart_q   <= 1'b0;
        end else begin
            prescCnt_q     <= prescCnt_d;
            blankCnt_q     <= blankCnt_d;
            sel_q          <= sel_d;
            shadowDigits_q <= shadowDigits_d;
            shadowEn_q     <= shadowEn_d;
            shadowDp_q     <= shadowDp_d;
            segN_q         <= segN_d;
            dpN_q          <= dpN_d;
            frameStart_q   <= frameStart_d;
        end
    end

    assign sel         = sel_q;
    assign seg_n       = segN_q;
    assign dp_n        = dpN_q;
    assign frame_start = frameStart_q;

endmodule

// File: doc/seven_segment_scan_controller.md
SEVEN_SEGMENT_SCAN_CONTROLLER -- requirements
Module: seven_segment_scan_controller

Interface
REQ-001 SHALL have parameter DIV, default 100000: clocks per digit slot (refresh tick period), legal range >= 2.
REQ-002 SHALL have parameter BLANK, default 2: ghost-blanking clocks after each digit change, legal range 0 <= BLANK < DIV.
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port en, input, 1: scan enable; low freezes the scan.
REQ-006 SHALL have port digits, input, 32: eight hex nibbles; digit k is digits[4k+3:4k].
REQ-007 SHALL have port digit_en, input, 8: per-digit enable; a 0 bit blanks that digit.
REQ-008 SHALL have port dp, input, 8: per-digit decimal point, active-high request.
REQ-009 SHALL have port sel, output, 3: digit index driving the downstream anode selector.
REQ-010 SHALL have port seg_n, output, 7: {g,f,e,d,c,b,a}, active-low.
REQ-011 SHALL have port dp_n, output, 1: decimal point, active-low.
REQ-012 SHALL have port frame_start, output, 1: one-clock pulse when sel wraps 7->0.

Function
REQ-013 Prescaler: counts 0..DIV-1 while en=1; tick = (count==DIV-1 && en); count returns to 0 after tick; holds its value while en=0.
REQ-014 On tick, sel SHALL increment modulo 8 at the same clock edge; sel changes only on tick.
REQ-015 Shadow registers (digits, digit_en, dp) SHALL load from the inputs only at the edge where sel goes 7->0; input changes mid-frame SHALL NOT appear until the next frame.
REQ-016 frame_start SHALL be 1 for exactly the clock following the 7->0 edge; 0 otherwise.
REQ-017 Blank counter: loads BLANK at every sel-change edge and decrements to 0; while nonzero, seg_n=7'h7F and dp_n=1.
REQ-018 When the blank counter is 0: if shadow digit_en[sel]=0, seg_n=7'h7F and dp_n=1; else seg_n=HEX(shadow nibble[sel]) and dp_n=~shadow dp[sel].
REQ-019 HEX table (seg_n): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-020 seg_n and dp_n SHALL be registered and consistent with the current sel on the same cycle; no combinational path from the digits input to the outputs.
REQ-021 en deasserted mid-slot: sel, prescaler and blank counter hold; seg_n/dp_n keep their current values; scanning resumes from the held count when en returns.
REQ-022 BLANK=0: no blank cycles; the new digit pattern appears on the same edge that sel changes.

Reset
REQ-023 rst=1 SHALL immediately (asynchronously) force: prescaler=0, sel=0, blank counter=0, shadow digits=0, shadow digit_en=0, shadow dp=0, seg_n=7'h7F, dp_n=1, frame_start=0.
REQ-024 After rst is released, the display stays blank until the first 7->0 wrap loads the shadow registers (first frame is blank by design).
REQ-025 rst asserted mid-frame or mid-blank SHALL abort immediately; no partial shadow load occurs.

Verification (DIV=4, BLANK=1 unless noted)
REQ-026 Reset then en=1, digits=32'h76543210, digit_en=8'hFF -> sel steps 0..7 every 4 clocks; seg_n stays 7'h7F for the first frame; frame_start pulses once after 32 clocks.
REQ-027 Second frame: each slot shows 1 blank clock then HEX(k), e.g. sel=0 -> 1000000, sel=1 -> 1111001; sel=7 -> 1111000.
REQ-028 Change digits to 32'hFFFFFFFF while sel=3 -> the current frame still shows 4..7; the next frame shows 0001110 on every digit.
REQ-029 digit_en=8'b11111110, dp=8'b00000100 -> digit 0 is always 7'h7F; digit 2 has dp_n=0; all other digits have dp_n=1.
REQ-030 en=0 for 10 clocks at sel=5 -> sel remains 5 and seg_n is unchanged; after en=1 the slot finishes its remaining prescaler counts.
REQ-031 rst pulse at sel=6 mid-blank -> all outputs go to reset values without waiting for clk; BLANK=0 rerun shows no blank clock between digits.
